// File: rtl/trigger_event_capture.sv
// Trigger event capture: timestamps each rising edge of trigger_in, tracks the signed
// peak sample over a latched window and queues {timestamp, peak} in a FWFT FIFO.
module trigger_event_capture #(
  parameter int width    = 12,
  parameter int ts_width = 32,
  parameter int depth    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       trigger_in,
  input  logic signed [width-1:0]    data_in,
  input  logic [15:0]                peak_window,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [ts_width-1:0]        ev_timestamp,
  output logic [width-1:0]           ev_peak,
  output logic [$clog2(depth):0]     fifo_level,
  output logic [15:0]                overflow_count,
  output logic                       busy
);

  localparam int aw = $clog2(depth);
  localparam int lw = aw + 1;
  localparam int dw = ts_width + width;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    PUSH
  } state_t;

  state_t state, state_nxt;

  logic [ts_width-1:0]     ts_cnt;
  logic [ts_width-1:0]     ts_reg;
  logic signed [width-1:0] peak_reg;
  logic [15:0]             cnt;
  logic                    trig_prev;
  logic                    trig_edge;

  logic [dw-1:0]           mem [depth];
  logic [aw-1:0]           wr_ptr;
  logic [aw-1:0]           rd_ptr;
  logic [aw-1:0]           rd_nxt;
  logic [dw-1:0]           wdata;
  logic                    full;
  logic                    push;
  logic                    drop;
  logic                    pop;

  assign trig_edge = trigger_in & ~trig_prev;
  assign busy      = (state != IDLE);

  assign full      = (fifo_level == lw'(depth));
  assign push      = (state == PUSH) && !full;
  assign drop      = (state == PUSH) && full;
  assign ev_valid  = (fifo_level != '0);
  assign pop       = ev_valid & ev_ready;
  assign wdata     = {ts_reg, peak_reg};
  assign rd_nxt    = rd_ptr + 1'b1;

  // Free-running timestamp and edge history; trig_prev resets high so a
  // trigger already asserted at reset release is not taken as an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt    <= '0;
      trig_prev <= 1'b1;
    end else begin
      ts_cnt    <= ts_cnt + 1'b1;
      trig_prev <= trigger_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (trig_edge) begin
          state_nxt = (peak_window == '0) ? PUSH : MEASURE;
        end
      end
      MEASURE: begin
        if (cnt == 16'd1) begin
          state_nxt = PUSH;
        end
      end
      PUSH:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Window length is latched into cnt at the edge; peak_window is not looked at again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_reg   <= '0;
      peak_reg <= '0;
      cnt      <= '0;
    end else begin
      if (state == IDLE && trig_edge) begin
        ts_reg   <= ts_cnt;
        peak_reg <= data_in;
        cnt      <= peak_window;
      end else if (state == MEASURE) begin
        if (data_in > peak_reg) begin
          peak_reg <= data_in;
        end
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_level     <= '0;
      overflow_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_nxt;
      end
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (drop && overflow_count != '1) begin
        overflow_count <= overflow_count + 1'b1;
      end
    end
  end

  // Registered head: a write into an empty (or emptying) FIFO bypasses memory,
  // otherwise a pop loads the next stored entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ev_timestamp <= '0;
      ev_peak      <= '0;
    end else begin
      if (push && (fifo_level == '0 || (fifo_level == lw'(1) && pop))) begin
        {ev_timestamp, ev_peak} <= wdata;
      end else if (pop && fifo_level > lw'(1)) begin
        {ev_timestamp, ev_peak} <= mem[rd_nxt];
      end
    end
  end

endmodule

// File: tb/tb_trigger_event_capture.sv
// Directed bench for trigger_event_capture: hand-picked sample windows, a small
// queue model of expected FIFO contents, and reset/overflow corner cases.
module tb_trigger_event_capture;

  localparam int W   = 12;
  localparam int TSW = 32;
  localparam int D   = 16;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                trigger_in = 1'b0;
  logic signed [W-1:0] data_in = '0;
  logic [15:0]         peak_window = '0;
  logic                ev_valid;
  logic                ev_ready = 1'b0;
  logic [TSW-1:0]      ev_timestamp;
  logic [W-1:0]        ev_peak;
  logic [$clog2(D):0]  fifo_level;
  logic [15:0]         overflow_count;
  logic                busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_ovf = 0;
  int busy_cycles = 0;
  logic valid_pre = 1'b0;

  logic [TSW-1:0]      q_ts [$];
  logic [W-1:0]        q_pk [$];
  logic signed [W-1:0] samp [16];

  trigger_event_capture #(
    .width   (W),
    .ts_width(TSW),
    .depth   (D)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .trigger_in    (trigger_in),
    .data_in       (data_in),
    .peak_window   (peak_window),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_timestamp  (ev_timestamp),
    .ev_peak       (ev_peak),
    .fifo_level    (fifo_level),
    .overflow_count(overflow_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_head(input string tag);
    check_eq({tag, "_valid"}, ev_valid, 1'b1);
    check_eq({tag, "_ts"}, ev_timestamp, q_ts[0]);
    check_eq({tag, "_peak"}, ev_peak, q_pk[0]);
  endtask

  task automatic pop_head;
    check_head("pop");
    ev_ready = 1'b1;
    tick;
    ev_ready = 1'b0;
    void'(q_ts.pop_front());
    void'(q_pk.pop_front());
    check_eq("pop_level", fifo_level, q_ts.size());
  endtask

  // Edge at the first tick, samples samp[0..w], then the PUSH clock with the
  // trigger low; peak_window is changed after the edge to prove it is latched.
  task automatic run_event(input int w, input bit pop_at_push);
    logic signed [W-1:0] pk;
    logic [TSW-1:0]      ts;
    bit                  was_full;
    ts = TSW'(cyc);
    pk = samp[0];
    busy_cycles = 0;
    for (int i = 0; i <= w; i++) begin
      if (i > 0 && samp[i] > pk) pk = samp[i];
      trigger_in  = 1'b1;
      data_in     = samp[i];
      peak_window = (i == 0) ? 16'(w) : 16'(w + 7);
      tick;
      if (busy) busy_cycles++;
    end
    valid_pre  = ev_valid;
    trigger_in = 1'b0;
    data_in    = 12'sh7FF;
    was_full   = (q_ts.size() >= D);
    if (pop_at_push && q_ts.size() > 0) begin
      check_head("pp");
      ev_ready = 1'b1;
      void'(q_ts.pop_front());
      void'(q_pk.pop_front());
    end
    tick;
    ev_ready = 1'b0;
    if (!was_full) begin
      q_ts.push_back(ts);
      q_pk.push_back(pk);
    end else if (exp_ovf < 65535) begin
      exp_ovf++;
    end
    check_eq("push_busy", busy, 1'b0);
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_valid"}, ev_valid, 1'b0);
    check_eq({tag, "_ts"}, ev_timestamp, '0);
    check_eq({tag, "_peak"}, ev_peak, '0);
    check_eq({tag, "_level"}, fifo_level, '0);
    check_eq({tag, "_ovf"}, overflow_count, '0);
    check_eq({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic release_reset;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_cleared("rst");
    release_reset;

    // Basic event: edge at the 10th clock, W=3, ramp 10,50,30,20
    repeat (9) tick;
    samp[0] = 12'sd10; samp[1] = 12'sd50; samp[2] = 12'sd30; samp[3] = 12'sd20;
    run_event(3, 1'b0);
    check_eq("basic_valid_pre", valid_pre, 1'b0);
    check_eq("basic_busy_cyc", busy_cycles, 4);
    check_eq("basic_valid", ev_valid, 1'b1);
    check_eq("basic_ts", ev_timestamp, 32'd9);
    check_eq("basic_peak", ev_peak, 12'd50);
    check_eq("basic_level", fifo_level, 1);
    pop_head;
    check_eq("basic_empty", ev_valid, 1'b0);

    // Negative samples, W=0, and signed extremes
    samp[0] = 12'shF00;
    run_event(0, 1'b0);
    check_eq("w0_peak", ev_peak, 12'hF00);
    pop_head;
    samp[0] = -12'sd5; samp[1] = -12'sd2; samp[2] = -12'sd9;
    run_event(2, 1'b0);
    check_eq("neg_peak", ev_peak, 12'hFFE);
    pop_head;
    samp[0] = 12'sh800; samp[1] = 12'sh800; samp[2] = 12'sh801;
    run_event(2, 1'b0);
    check_eq("min_peak", ev_peak, 12'h801);
    samp[0] = 12'sh7FF; samp[1] = 12'sh800; samp[2] = 12'sd0;
    run_event(2, 1'b0);
    pop_head;
    check_eq("max_peak", ev_peak, 12'h7FF);
    pop_head;

    // Trigger held high 50 clocks: one event, peak from the first 6 samples only
    q_ts.push_back(TSW'(cyc));
    q_pk.push_back(12'd5);
    trigger_in  = 1'b1;
    peak_window = 16'd5;
    for (int i = 0; i < 50; i++) begin
      data_in = 12'(i);
      tick;
    end
    trigger_in = 1'b0;
    tick;
    check_eq("held_level", fifo_level, 1);
    check_eq("held_busy", busy, 1'b0);

    // Second edge at N+3 inside a W=5 window is ignored
    begin
      logic        trig_seq [7];
      logic [11:0] dat_seq  [7];
      trig_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      dat_seq  = '{12'd3, 12'd1, 12'd2, 12'd4, 12'd9, 12'd6, 12'd100};
      q_ts.push_back(TSW'(cyc));
      q_pk.push_back(12'd9);
      peak_window = 16'd5;
      for (int i = 0; i < 7; i++) begin
        trigger_in = trig_seq[i];
        data_in    = dat_seq[i];
        tick;
      end
      repeat (3) tick;
    end
    check_eq("win_level", fifo_level, 2);
    check_eq("win_ovf", overflow_count, 0);
    pop_head;
    pop_head;

    // Overflow: 20 events with W=1 spaced 4 clocks apart, no readout
    for (int k = 0; k < 20; k++) begin
      samp[0] = 12'(k * 10);
      samp[1] = 12'(-k);
      run_event(1, 1'b0);
      tick;
    end
    check_eq("ovf_level", fifo_level, 16);
    check_eq("ovf_count", overflow_count, 4);
    check_eq("ovf_model", exp_ovf, 4);
    samp[0] = 12'sd77; samp[1] = 12'sd78;
    run_event(1, 1'b1);
    check_eq("fullpp_level", fifo_level, 15);
    check_eq("fullpp_ovf", overflow_count, 5);
    check_head("fullpp_head");

    // Backpressure: refill to 16, drain with ready toggling 0,1
    samp[0] = -12'sd100; samp[1] = 12'sd300;
    run_event(1, 1'b0);
    check_eq("bp_level", fifo_level, 16);
    while (q_ts.size() > 0) begin
      ev_ready = 1'b0;
      tick;
      check_head("hold");
      pop_head;
    end
    check_eq("bp_empty", ev_valid, 1'b0);

    // Pointer wrap: 40 same-cycle push/pop pairs at level 1
    samp[0] = 12'sd1;
    run_event(0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      samp[0] = 12'(k * 37 - 600);
      run_event(0, 1'b1);
      check_eq("wrap_level", fifo_level, 1);
    end
    pop_head;
    check_eq("wrap_empty", ev_valid, 1'b0);

    // Reset mid-window with three entries stored
    for (int k = 0; k < 3; k++) begin
      samp[0] = 12'(k + 1);
      run_event(0, 1'b0);
    end
    check_eq("pre_rst_level", fifo_level, 3);
    trigger_in  = 1'b1;
    peak_window = 16'd6;
    data_in     = 12'sd42;
    repeat (3) tick;
    #2;
    reset = 1'b1;
    #1;
    check_cleared("async_rst");
    q_ts.delete();
    q_pk.delete();
    exp_ovf = 0;
    release_reset;
    repeat (5) tick;
    check_eq("held_rel_busy", busy, 1'b0);
    check_eq("held_rel_level", fifo_level, 0);
    trigger_in = 1'b0;
    tick;
    samp[0] = -12'sd7; samp[1] = -12'sd3; samp[2] = -12'sd8;
    run_event(2, 1'b0);
    check_eq("post_rst_ts", ev_timestamp, 32'd6);
    pop_head;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
